// File: rtl/single_cycle_mips.sv
// single_cycle_mips: 32-bit single-cycle MIPS subset core.
// Fetch, decode, execute and retire one instruction per clk edge.

module mips_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  // Contents are loaded from outside the design
  logic [31:0] memory [0:WORDS-1];

  assign rdata = memory[addr];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regFile [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regFile[i] <= '0;
      end
    end else if (we && wa != 5'd0) begin
      regFile[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regFile[ra2];
endmodule

module mips_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      memory[addr] <= wd;
    end
  end

  assign rdata = memory[addr];
endmodule

module single_cycle_mips #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        Jump
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_SLT, ALU_LUI
  } alu_op_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [15:0] imm;
  logic        rtype, reg_dst, zext;
  logic        mem_read, mem_write, is_bne;
  logic        taken;
  alu_op_t     alu_op;
  logic [31:0] rd1, rd2, imm_ext, src_b;
  logic [31:0] alu_y, dm_rdata, wb;
  logic [31:0] pc_plus4, br_target, pc_next;

  mips_imem #(.WORDS(IMEM_WORDS)) inst_mem (
    .addr  (pc[IAW+1:2]),
    .rdata (instruction)
  );

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign imm   = instruction[15:0];
  assign funct = instruction[5:0];
  assign rtype = (op == 6'h00);

  // Unknown or unsupported encodings fall to default: a pure pc+4 nop
  always_comb begin
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    Branch    = 1'b0;
    Jump      = 1'b0;
    reg_dst   = 1'b0;
    zext      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_bne    = 1'b0;
    alu_op    = ALU_ADD;
    unique case (1'b1)
      rtype && funct == 6'h20: begin
        RegWrite = 1'b1;
        reg_dst  = 1'b1;
      end
      rtype && funct == 6'h22: begin
        RegWrite = 1'b1;
        reg_dst  = 1'b1;
        alu_op   = ALU_SUB;
      end
      rtype && funct == 6'h24: begin
        RegWrite = 1'b1;
        reg_dst  = 1'b1;
        alu_op   = ALU_AND;
      end
      rtype && funct == 6'h25: begin
        RegWrite = 1'b1;
        reg_dst  = 1'b1;
        alu_op   = ALU_OR;
      end
      rtype && funct == 6'h2A: begin
        RegWrite = 1'b1;
        reg_dst  = 1'b1;
        alu_op   = ALU_SLT;
      end
      op == 6'h08: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
      end
      op == 6'h0C: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        zext     = 1'b1;
        alu_op   = ALU_AND;
      end
      op == 6'h0D: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        zext     = 1'b1;
        alu_op   = ALU_OR;
      end
      op == 6'h0F: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        alu_op   = ALU_LUI;
      end
      op == 6'h0A: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        alu_op   = ALU_SLT;
      end
      op == 6'h23: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        mem_read = 1'b1;
      end
      op == 6'h2B: begin
        ALUSrc    = 1'b1;
        mem_write = 1'b1;
      end
      op == 6'h04: Branch = 1'b1;
      op == 6'h05: begin
        Branch = 1'b1;
        is_bne = 1'b1;
      end
      op == 6'h02: Jump = 1'b1;
      default: ;
    endcase
  end

  mips_regfile reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .we  (RegWrite),
    .wa  (wa),
    .wd  (wb),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign imm_ext = zext ? {16'h0, imm}
                        : {{16{imm[15]}}, imm};
  assign src_b   = ALUSrc ? imm_ext : rd2;

  always_comb begin
    alu_y = '0;
    unique case (alu_op)
      ALU_ADD: alu_y = rd1 + src_b;
      ALU_SUB: alu_y = rd1 - src_b;
      ALU_AND: alu_y = rd1 & src_b;
      ALU_OR:  alu_y = rd1 | src_b;
      ALU_SLT: alu_y = {31'b0, $signed(rd1) < $signed(src_b)};
      ALU_LUI: alu_y = {imm, 16'h0};
      default: alu_y = '0;
    endcase
  end

  // Word index is the low address bits taken unshifted
  mips_dmem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk   (clk),
    .we    (mem_write && !rst),
    .addr  (alu_y[DAW-1:0]),
    .wd    (rd2),
    .rdata (dm_rdata)
  );

  assign wb = mem_read ? dm_rdata : alu_y;
  assign wa = reg_dst ? rd : rt;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign taken     = Branch && ((rd1 == rd2) != is_bne);

  always_comb begin
    pc_next = pc_plus4;
    if (Jump) begin
      pc_next = {pc_plus4[31:28], instruction[25:0], 2'b00};
    end else if (taken) begin
      pc_next = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end
endmodule

// File: tb/tb_single_cycle_mips.sv
// tb_single_cycle_mips: directed scenarios plus random programs
// checked against an instruction-level model of the ISA subset.

module tb_single_cycle_mips;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, instruction;
  logic        RegWrite, ALUSrc, Branch, Jump;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_imem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc;

  single_cycle_mips dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .Jump        (Jump)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rt_i(
    input logic [5:0] f, input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] it_i(
    input logic [5:0] o, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] jt_i(input logic [25:0] tg);
    return {6'h02, tg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) m_imem[i] = 32'h0;
  endtask

  task automatic push_prog();
    for (int i = 0; i < 256; i++) dut.inst_mem.memory[i] = m_imem[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Expected {RegWrite, ALUSrc, Branch, Jump} from the ISA tables
  function automatic logic [3:0] model_ctrl(input logic [31:0] w);
    logic [5:0] o, f;
    logic rw, as;
    o  = w[31:26];
    f  = w[5:0];
    rw = (o == 6'h00 && f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
      || (o inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h23});
    as = o inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h23, 6'h2B};
    return {rw, as, o inside {6'h04, 6'h05}, o == 6'h02};
  endfunction

  task automatic model_step();
    logic [31:0] w, a, b, se, ze, p4, nxt, val, addr;
    logic [15:0] im;
    logic [4:0]  dst;
    logic        wr;
    w   = m_imem[m_pc[9:2]];
    a   = m_regs[w[25:21]];
    b   = m_regs[w[20:16]];
    im  = w[15:0];
    se  = 32'($signed(im));
    ze  = {16'h0, im};
    p4  = m_pc + 4;
    nxt = p4;
    wr  = 1'b1;
    dst = w[20:16];
    val = 32'h0;
    addr = a + se;
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        case (w[5:0])
          6'h20: val = a + b;
          6'h22: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h2A: val = ($signed(a) < $signed(b)) ? 1 : 0;
          default: wr = 1'b0;
        endcase
      end
      6'h08: val = a + se;
      6'h0C: val = a & ze;
      6'h0D: val = a | ze;
      6'h0F: val = ze << 16;
      6'h0A: val = ($signed(a) < $signed(se)) ? 1 : 0;
      6'h23: val = m_dmem[addr % 256];
      6'h2B: begin
        wr = 1'b0;
        m_dmem[addr % 256] = b;
      end
      6'h04: begin
        wr = 1'b0;
        if (a == b) nxt = p4 + se * 4;
      end
      6'h05: begin
        wr = 1'b0;
        if (a != b) nxt = p4 + se * 4;
      end
      6'h02: begin
        wr = 1'b0;
        nxt = {p4[31:28], w[25:0], 2'b00};
      end
      default: wr = 1'b0;
    endcase
    if (wr && dst != 0) m_regs[dst] = val;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    s  = 5'($urandom_range(0, 7));
    t  = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 17))
      0: return rt_i(6'h20, s, t, d);
      1: return rt_i(6'h22, s, t, d);
      2: return rt_i(6'h24, s, t, d);
      3: return rt_i(6'h25, s, t, d);
      4: return rt_i(6'h2A, s, t, d);
      5: return it_i(6'h08, s, t, im);
      6: return it_i(6'h0C, s, t, im);
      7: return it_i(6'h0D, s, t, im);
      8: return it_i(6'h0F, s, t, im);
      9: return it_i(6'h0A, s, t, im);
      10: return it_i(6'h23, s, t, 16'($urandom_range(0, 300)));
      11: return it_i(6'h2B, s, t, 16'($urandom_range(0, 300)));
      12: return it_i(6'h04, s, t, 16'($urandom_range(0, 6)));
      13: return it_i(6'h05, s, t, 16'($urandom_range(0, 6)));
      14: return jt_i(26'($urandom_range(5, 255)));
      15: return it_i(6'h3F, s, t, im);
      16: return rt_i(6'h21, s, t, d);
      default: return it_i(6'h08, s, t, 16'($urandom_range(0, 9)));
    endcase
  endfunction

  task automatic test_reset();
    logic bad;
    clear_prog();
    m_imem[0] = it_i(6'h08, 5'd0, 5'd8, 16'd5);
    m_imem[1] = it_i(6'h08, 5'd0, 5'd9, 16'd3);
    m_imem[2] = it_i(6'h08, 5'd0, 5'd10, 16'd7);
    push_prog();
    do_reset();
    tick();
    tick();
    tick();
    vectors++;
    if (dut.reg_file.regFile[8] !== 32'd5) begin
      errors++;
      $display("FAIL reset_dirty: got %h expected %h",
               dut.reg_file.regFile[8], 32'd5);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 0", pc);
    end
    bad = 1'b0;
    for (int i = 0; i < 32; i++)
      if (dut.reg_file.regFile[i] !== 32'h0) bad = 1'b1;
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL reset_regs: got nonzero expected all 0");
    end
    vectors++;
    if (instruction !== m_imem[0] || RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_decode: got %h/%b expected %h/1",
               instruction, RegWrite, m_imem[0]);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL reset_step1: got %h expected 4", pc);
    end
    tick();
    vectors++;
    if (pc !== 32'h8) begin
      errors++;
      $display("FAIL reset_step2: got %h expected 8", pc);
    end
  endtask

  task automatic test_alu();
    clear_prog();
    m_imem[0] = it_i(6'h08, 5'd0, 5'd8, 16'd5);
    m_imem[1] = it_i(6'h08, 5'd0, 5'd9, 16'd3);
    m_imem[2] = rt_i(6'h20, 5'd8, 5'd9, 5'd10);
    m_imem[3] = rt_i(6'h22, 5'd9, 5'd8, 5'd11);
    m_imem[4] = rt_i(6'h2A, 5'd11, 5'd8, 5'd15);
    push_prog();
    do_reset();
    tick();
    tick();
    vectors++;
    if (dut.reg_file.regFile[8] !== 32'd5 ||
        dut.reg_file.regFile[9] !== 32'd3) begin
      errors++;
      $display("FAIL alu_addi: got %h,%h expected 5,3",
               dut.reg_file.regFile[8], dut.reg_file.regFile[9]);
    end
    vectors++;
    if (RegWrite !== 1'b1 || ALUSrc !== 1'b0) begin
      errors++;
      $display("FAIL alu_add_ctrl: got rw=%b as=%b expected 1,0",
               RegWrite, ALUSrc);
    end
    tick();
    vectors++;
    if (dut.reg_file.regFile[10] !== 32'd8) begin
      errors++;
      $display("FAIL alu_add: got %h expected 8",
               dut.reg_file.regFile[10]);
    end
    tick();
    vectors++;
    if (dut.reg_file.regFile[11] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL alu_sub: got %h expected fffffffe",
               dut.reg_file.regFile[11]);
    end
    tick();
    vectors++;
    if (dut.reg_file.regFile[15] !== 32'd1) begin
      errors++;
      $display("FAIL alu_slt: got %h expected 1",
               dut.reg_file.regFile[15]);
    end
  endtask

  task automatic test_memory();
    clear_prog();
    m_imem[0] = it_i(6'h0F, 5'd0, 5'd16, 16'h1001);
    m_imem[1] = it_i(6'h0D, 5'd16, 5'd16, 16'h0010);
    m_imem[2] = it_i(6'h08, 5'd0, 5'd10, 16'd8);
    m_imem[3] = it_i(6'h2B, 5'd16, 5'd10, 16'd0);
    m_imem[4] = it_i(6'h23, 5'd16, 5'd17, 16'd0);
    push_prog();
    do_reset();
    tick();
    tick();
    tick();
    vectors++;
    if (dut.reg_file.regFile[16] !== 32'h1001_0010) begin
      errors++;
      $display("FAIL mem_base: got %h expected 10010010",
               dut.reg_file.regFile[16]);
    end
    vectors++;
    if (RegWrite !== 1'b0 || ALUSrc !== 1'b1) begin
      errors++;
      $display("FAIL mem_sw_ctrl: got rw=%b as=%b expected 0,1",
               RegWrite, ALUSrc);
    end
    tick();
    vectors++;
    if (dut.data_mem.memory[16] !== 32'd8) begin
      errors++;
      $display("FAIL mem_sw: got %h expected 8",
               dut.data_mem.memory[16]);
    end
    tick();
    vectors++;
    if (dut.reg_file.regFile[17] !== 32'd8) begin
      errors++;
      $display("FAIL mem_lw: got %h expected 8",
               dut.reg_file.regFile[17]);
    end
  endtask

  task automatic test_branch_jump();
    clear_prog();
    m_imem[0]  = it_i(6'h08, 5'd0, 5'd8, 16'd5);
    m_imem[8]  = it_i(6'h04, 5'd8, 5'd8, 16'd2);
    m_imem[9]  = it_i(6'h08, 5'd0, 5'd12, 16'd99);
    m_imem[10] = it_i(6'h08, 5'd0, 5'd12, 16'd98);
    m_imem[11] = it_i(6'h05, 5'd8, 5'd8, 16'd2);
    m_imem[12] = jt_i(26'h000004);
    push_prog();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (pc !== 32'h20 || Branch !== 1'b1 || Jump !== 1'b0) begin
      errors++;
      $display("FAIL beq_ctrl: got pc=%h br=%b j=%b expected 20,1,0",
               pc, Branch, Jump);
    end
    tick();
    vectors++;
    if (pc !== 32'h2C || dut.reg_file.regFile[12] !== 32'h0) begin
      errors++;
      $display("FAIL beq_taken: got pc=%h t4=%h expected 2c,0",
               pc, dut.reg_file.regFile[12]);
    end
    vectors++;
    if (Branch !== 1'b1) begin
      errors++;
      $display("FAIL bne_ctrl: got %b expected 1", Branch);
    end
    tick();
    vectors++;
    if (pc !== 32'h30) begin
      errors++;
      $display("FAIL bne_not_taken: got %h expected 30", pc);
    end
    vectors++;
    if (Jump !== 1'b1 || Branch !== 1'b0) begin
      errors++;
      $display("FAIL j_ctrl: got j=%b br=%b expected 1,0", Jump, Branch);
    end
    tick();
    vectors++;
    if (pc !== 32'h10) begin
      errors++;
      $display("FAIL j_target: got %h expected 10", pc);
    end
  endtask

  task automatic test_zero_protect();
    clear_prog();
    m_imem[0] = it_i(6'h08, 5'd0, 5'd0, 16'd7);
    m_imem[1] = it_i(6'h08, 5'd0, 5'd9, 16'd9);
    m_imem[2] = it_i(6'h3F, 5'd9, 5'd8, 16'h1234);
    m_imem[3] = rt_i(6'h21, 5'd9, 5'd9, 5'd8);
    push_prog();
    do_reset();
    tick();
    vectors++;
    if (dut.reg_file.regFile[0] !== 32'h0 || pc !== 32'h4) begin
      errors++;
      $display("FAIL zero_reg: got r0=%h pc=%h expected 0,4",
               dut.reg_file.regFile[0], pc);
    end
    tick();
    vectors++;
    if ({RegWrite, ALUSrc, Branch, Jump} !== 4'b0000) begin
      errors++;
      $display("FAIL undef_ctrl: got %b expected 0000",
               {RegWrite, ALUSrc, Branch, Jump});
    end
    tick();
    vectors++;
    if (pc !== 32'hC || dut.reg_file.regFile[8] !== 32'h0) begin
      errors++;
      $display("FAIL undef_op: got pc=%h t0=%h expected c,0",
               pc, dut.reg_file.regFile[8]);
    end
    tick();
    vectors++;
    if (pc !== 32'h10 || dut.reg_file.regFile[8] !== 32'h0) begin
      errors++;
      $display("FAIL undef_funct: got pc=%h t0=%h expected 10,0",
               pc, dut.reg_file.regFile[8]);
    end
  endtask

  task automatic test_random(input int round);
    logic [31:0] w;
    logic [3:0]  ctrl;
    int          bad;
    // Prologue fills every data word with its own index
    m_imem[0] = it_i(6'h08, 5'd0, 5'd1, 16'd0);
    m_imem[1] = it_i(6'h08, 5'd0, 5'd2, 16'd256);
    m_imem[2] = it_i(6'h2B, 5'd1, 5'd1, 16'd0);
    m_imem[3] = it_i(6'h08, 5'd1, 5'd1, 16'd1);
    m_imem[4] = it_i(6'h05, 5'd1, 5'd2, 16'hFFFD);
    for (int i = 5; i < 256; i++) m_imem[i] = rand_instr();
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'h0;
    push_prog();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      w    = m_imem[m_pc[9:2]];
      ctrl = model_ctrl(w);
      vectors++;
      if (pc !== m_pc || instruction !== w) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand_fetch r%0d c%0d: got %h/%h expected %h/%h",
                   round, c, pc, instruction, m_pc, w);
      end
      vectors++;
      if ({RegWrite, ALUSrc, Branch, Jump} !== ctrl) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand_ctrl r%0d c%0d: got %b expected %b",
                   round, c, {RegWrite, ALUSrc, Branch, Jump}, ctrl);
      end
      model_step();
      tick();
      bad = -1;
      for (int i = 0; i < 32; i++)
        if (dut.reg_file.regFile[i] !== m_regs[i]) bad = i;
      vectors++;
      if (bad >= 0) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand_regs r%0d c%0d: r%0d got %h expected %h",
                   round, c, bad, dut.reg_file.regFile[bad], m_regs[bad]);
      end
    end
    bad = -1;
    for (int i = 0; i < 256; i++)
      if (dut.data_mem.memory[i] !== m_dmem[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL rand_dmem r%0d: [%0d] got %h expected %h",
               round, bad, dut.data_mem.memory[bad], m_dmem[bad]);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_branch_jump();
    test_zero_protect();
    for (int r = 0; r < 3; r++) test_random(r);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
